// File: rtl/dm_ctrl_pkg.sv
// Shared types and default sizing for the data-memory access controller.
package dm_ctrl_pkg;

  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int RD_WAIT = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SET   = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    VFY      = 3'd5,
    RESP     = 3'd6
  } dm_state_e;

endpackage

// File: rtl/dm_ctrl_wait_cnt.sv
// Loadable down-counter; done_o is high once the count has drained to zero.
module dm_ctrl_wait_cnt #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: load wins over decrement, saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access controller: one load/store per handshake, clean dm_we pulse.
// Optional store read-back verification is enabled by DM_CTRL_WR_VERIFY_EN.
module dm_ctrl #(
  parameter int AW      = dm_ctrl_pkg::AW,
  parameter int DW      = dm_ctrl_pkg::DW,
  parameter int RD_WAIT = dm_ctrl_pkg::RD_WAIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic [AW-1:0] read_addr,
  output logic [AW-1:0] write_addr,
  output logic [DW-1:0] write_data,
  output logic          dm_we,
  input  logic [DW-1:0] read_data
);

  import dm_ctrl_pkg::*;

  localparam int            CW      = $clog2(RD_WAIT + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT);

  dm_state_e     state_q, state_d;
  logic [AW-1:0] read_addr_q, read_addr_d;
  logic [AW-1:0] write_addr_q, write_addr_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          dm_we_q, dm_we_d;
  logic          busy_q, busy_d;
  logic          req_ready_q, req_ready_d;
  logic          cnt_load_s, cnt_en_s, cnt_done_s;
  logic [CW-1:0] cnt_val_s;
`ifdef DM_CTRL_WR_VERIFY_EN
  // the verify read address only moves at the WR_HOLD edge, so it gets exactly RD_WAIT settle cycles
  localparam logic [CW-1:0] VFY_LOAD = CW'(RD_WAIT - 1);
  logic          rsp_err_q, rsp_err_d;
`endif

  dm_ctrl_wait_cnt #(.CW(CW)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .en_i       (cnt_en_s),
    .done_o     (cnt_done_s)
  );

  // next-state, memory port and response logic
  always_comb begin
    state_d      = state_q;
    read_addr_d  = read_addr_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    rsp_rdata_d  = rsp_rdata_q;
    cnt_load_s   = 1'b0;
    cnt_en_s     = 1'b0;
    cnt_val_s    = RD_LOAD;
`ifdef DM_CTRL_WR_VERIFY_EN
    rsp_err_d    = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            write_addr_d = req_addr;
            write_data_d = req_wdata;
            state_d      = WR_SET;
          end else begin
            read_addr_d  = req_addr;
            cnt_load_s   = 1'b1;
            state_d      = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (cnt_done_s) begin
          rsp_rdata_d = read_data;
`ifdef DM_CTRL_WR_VERIFY_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = RESP;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      WR_SET:   state_d = WR_PULSE;
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD: begin
`ifdef DM_CTRL_WR_VERIFY_EN
        read_addr_d = write_addr_q;
        cnt_load_s  = 1'b1;
        cnt_val_s   = VFY_LOAD;
        state_d     = VFY;
`else
        rsp_rdata_d = write_data_q;
        state_d     = RESP;
`endif
      end
`ifdef DM_CTRL_WR_VERIFY_EN
      VFY: begin
        if (cnt_done_s) begin
          rsp_rdata_d = read_data;
          rsp_err_d   = (read_data != write_data_q);
          state_d     = RESP;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // handshake and strobe outputs are registered from the next state
    rsp_valid_d = (state_d == RESP);
    dm_we_d     = (state_d == WR_PULSE);
    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
  end

  // state and output registers; reset also kills an in-flight dm_we pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      rsp_rdata_q  <= '0;
      rsp_valid_q  <= 1'b0;
      dm_we_q      <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      read_addr_q  <= read_addr_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      dm_we_q      <= dm_we_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
    end
  end

`ifdef DM_CTRL_WR_VERIFY_EN
  // read-back mismatch flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign read_addr  = read_addr_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign dm_we      = dm_we_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed scoreboard bench for dm_ctrl (default RD_WAIT and an RD_WAIT=3 instance).
module tb_dm_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_err, busy, dm_we;
  logic [31:0] rsp_rdata, write_data, read_data;
  logic [15:0] read_addr, write_addr;

  logic        r3_valid, r3_we;
  logic [15:0] r3_addr;
  logic [31:0] r3_wdata;
  logic        r3_ready, r3_rsp_valid, r3_rsp_err, r3_busy, r3_dm_we;
  logic [31:0] r3_rsp_rdata, r3_write_data, r3_rdata;
  logic [15:0] r3_read_addr, r3_write_addr;

  logic [31:0] mem [0:15];
  logic        preload;
  logic        corrupt;
  logic [15:0] wa_fall;
  int          we_hi;
  int          rsp_n;
  int          n_req;
  int          n_tests;
  int          n_fail;
  exp_t        sb [$];

  dm_ctrl u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .read_addr(read_addr), .write_addr(write_addr), .write_data(write_data),
    .dm_we(dm_we), .read_data(read_data)
  );

  dm_ctrl #(.RD_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_we(r3_we),
    .req_addr(r3_addr), .req_wdata(r3_wdata),
    .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata), .rsp_err(r3_rsp_err), .busy(r3_busy),
    .read_addr(r3_read_addr), .write_addr(r3_write_addr), .write_data(r3_write_data),
    .dm_we(r3_dm_we), .read_data(r3_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: write commits on the falling edge of dm_we
  always @(negedge dm_we or posedge preload) begin
    if (preload) mem[2] <= 32'h0000_0011;
    else begin
      mem[write_addr[3:0]] <= write_data;
      wa_fall              <= write_addr;
    end
  end
  assign read_data = mem[read_addr[3:0]] ^ {31'b0, corrupt};

  always @(negedge clk) begin
    if (dm_we)     we_hi <= we_hi + 1;
    if (rsp_valid) rsp_n <= rsp_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
      chk({tag, "_err"},   64'(err),   64'(e.err));
      chk({tag, "_lat"},   64'(lat),   64'(e.lat));
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is seen.
  task automatic run_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input logic hold, input string tag, output int waits);
    exp_t e;
    int   k;
    logic hs_bad;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    waits = 0;
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    n_req++;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    k = 0;
    hs_bad = 1'b0;
    while (!rsp_valid && k < 40) begin
      if (req_ready || !busy) hs_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    if (req_ready) hs_bad = 1'b1;
    chk({tag, "_busy_not_ready"}, 64'(hs_bad), 64'd0);
    pop_chk(tag, rsp_rdata, rsp_err, k);
  endtask

  initial begin
    int   w, w2, k, we0;
    exp_t e;
    n_tests = 0; n_fail = 0; n_req = 0; we_hi = 0; rsp_n = 0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 32'h0;
    r3_valid = 1'b0; r3_we = 1'b0; r3_addr = 16'h0; r3_wdata = 32'h0; r3_rdata = 32'h0;
    corrupt = 1'b0; preload = 1'b0;
    rst = 1'b1;
    #1 preload = 1'b1;
    #1 preload = 1'b0;
    // reset values
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_rspv",  64'(rsp_valid), 64'd0);
    chk("rst_dmwe",  64'(dm_we),     64'd0);
    chk("rst_outs",  64'({rsp_rdata, read_addr, write_addr}), 64'd0);
    chk("rst_wdata", 64'({write_data, rsp_err}), 64'd0);
    chk("rst_ready3", 64'(r3_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // store then load back
    we0 = we_hi;
`ifdef DM_CTRL_WR_VERIFY_EN
    run_req(1'b1, 16'h0005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4, 1'b0, "st5", w);
`else
    run_req(1'b1, 16'h0005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3, 1'b0, "st5", w);
`endif
    chk("st5_we_cycles", 64'(we_hi - we0), 64'd1);
    chk("st5_wa_at_fall", 64'(wa_fall), 64'h5);
    run_req(1'b0, 16'h0005, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, "ld5", w);
    chk("ld5_raddr", 64'(read_addr), 64'h5);

    // preloaded location
    run_req(1'b0, 16'h0002, 32'h0, 32'h0000_0011, 1'b0, 2, 1'b0, "ld2", w);
    @(negedge clk);
    chk("ld2_single_pulse", 64'(rsp_valid), 64'd0);

    // back-to-back stores with req_valid held high
    we0 = we_hi;
`ifdef DM_CTRL_WR_VERIFY_EN
    run_req(1'b1, 16'h0000, 32'hA5A5_0000, 32'hA5A5_0000, 1'b0, 4, 1'b1, "b2b0", w);
    chk("b2b0_we_cycles", 64'(we_hi - we0), 64'd1);
    run_req(1'b1, 16'h0001, 32'h5A5A_0001, 32'h5A5A_0001, 1'b0, 4, 1'b0, "b2b1", w2);
`else
    run_req(1'b1, 16'h0000, 32'hA5A5_0000, 32'hA5A5_0000, 1'b0, 3, 1'b1, "b2b0", w);
    chk("b2b0_we_cycles", 64'(we_hi - we0), 64'd1);
    run_req(1'b1, 16'h0001, 32'h5A5A_0001, 32'h5A5A_0001, 1'b0, 3, 1'b0, "b2b1", w2);
`endif
    chk("b2b1_accept_after_resp", 64'(w2), 64'd1);
    chk("b2b_we_cycles", 64'(we_hi - we0), 64'd2);
    chk("b2b_mem0", 64'(mem[0]), 64'hA5A5_0000);
    chk("b2b_mem1", 64'(mem[1]), 64'h5A5A_0001);

`ifdef DM_CTRL_WR_VERIFY_EN
    // corrupted read-back is flagged
    corrupt = 1'b1;
    run_req(1'b1, 16'h0003, 32'h1234_5678, 32'h1234_5679, 1'b1, 4, 1'b0, "vfy", w);
    corrupt = 1'b0;
`endif

    // reset in the middle of the write pulse
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0007; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_dmwe_high", 64'(dm_we), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_dmwe_low", 64'(dm_we), 64'd0);
    chk("rstmid_ready", 64'(req_ready), 64'd1);
    chk("rstmid_busy",  64'(busy), 64'd0);
    chk("rstmid_outs",  64'({rsp_valid, write_addr, write_data, rsp_rdata}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_req(1'b0, 16'h0002, 32'h0, 32'h0000_0011, 1'b0, 2, 1'b0, "ld2_after_rst", w);

    // RD_WAIT=3: read_data is captured only on the final wait edge
    @(negedge clk);
    r3_valid = 1'b1; r3_we = 1'b0; r3_addr = 16'h0009; r3_rdata = 32'h1111_0000;
    chk("rw3_ready", 64'(r3_ready), 64'd1);
    @(posedge clk);
    e.rdata = 32'h3333_0003; e.err = 1'b0; e.lat = 4;
    sb.push_back(e);
    @(negedge clk);
    r3_valid = 1'b0;
    k = 0;
    while (!r3_rsp_valid && k < 40) begin
      if (k == 3) r3_rdata = 32'h3333_0003;
      else        r3_rdata = 32'h1111_0000 + 32'(k);
      @(negedge clk);
      k++;
    end
    r3_rdata = 32'h4444_4444;
    pop_chk("rw3", r3_rsp_rdata, r3_rsp_err, k);
    chk("rw3_raddr", 64'(r3_read_addr), 64'h9);
    @(negedge clk);
    chk("rw3_single_pulse", 64'(r3_rsp_valid), 64'd0);
    chk("rw3_no_write", 64'({r3_dm_we, r3_write_addr, r3_write_data, r3_busy}), 64'd0);

    repeat (2) @(negedge clk);
    chk("rsp_pulse_count", 64'(rsp_n), 64'(n_req));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
